// File: rtl/vend_sequencer_if.sv
// Bus between the vend sequencer and its environment: sale/coin inputs, the
// change-maker operands and verdict, and the coin dispense handshake.
interface vend_sequencer_if;
  logic       item_valid;
  logic [3:0] item_cost;
  logic       coin_valid;
  logic [2:0] coin_value;
  logic       cancel;
  logic [3:0] Cost;
  logic [3:0] Paid;
  logic [1:0] Pentagons;
  logic [1:0] Triangles;
  logic [1:0] Circles;
  logic [2:0] FirstCoin;
  logic [2:0] SecondCoin;
  logic [3:0] Remaining;
  logic       ExactAmount;
  logic       NotEnoughChange;
  logic       CoughUpMore;
  logic       coin_reject;
  logic       disp_valid;
  logic [2:0] disp_coin;
  logic       disp_ready;
  logic       sale_ok;
  logic       sale_fail;
  logic       busy;

  modport master (
    output item_valid, item_cost, coin_valid, coin_value, cancel,
    output FirstCoin, SecondCoin, Remaining, ExactAmount, NotEnoughChange, CoughUpMore,
    output disp_ready,
    input  Cost, Paid, Pentagons, Triangles, Circles,
    input  coin_reject, disp_valid, disp_coin, sale_ok, sale_fail, busy
  );

  modport slave (
    input  item_valid, item_cost, coin_valid, coin_value, cancel,
    input  FirstCoin, SecondCoin, Remaining, ExactAmount, NotEnoughChange, CoughUpMore,
    input  disp_ready,
    output Cost, Paid, Pentagons, Triangles, Circles,
    output coin_reject, disp_valid, disp_coin, sale_ok, sale_fail, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending sale controller: collects coins, keeps the coin inventory, consults the
// combinational change maker and dispenses change or refunds one coin at a time.
module vend_sequencer #(
  parameter logic [1:0] INIT_PENT = 2'd3,
  parameter logic [1:0] INIT_TRI  = 2'd3,
  parameter logic [1:0] INIT_CIR  = 2'd3
) (
  input logic            clock,
  input logic            reset_L,
  vend_sequencer_if.slave bus
);
  localparam logic [2:0] PENT = 3'd5;
  localparam logic [2:0] TRIC = 3'd3;
  localparam logic [2:0] CIRC = 3'd1;

  typedef enum logic [2:0] {IDLE, COLLECT, DECIDE, DISPENSE, REFUND} state_t;

  state_t     state;
  logic [3:0] cost;
  logic [3:0] paid;
  logic [1:0] pent_cnt, tri_cnt, cir_cnt;
  logic [1:0] ins_pent, ins_tri, ins_cir;
  logic [2:0] queue_tail;
  logic       queue_two;
  logic       coin_reject, disp_valid, sale_ok, sale_fail;
  logic [2:0] disp_coin;

  logic [4:0] paid_sum;
  logic       coin_legal, coin_room, coin_ok, handshake;
  logic [2:0] chg_head;
  logic       chg_two;
  logic [1:0] left_pent, left_tri, left_cir;
  logic [2:0] refund_coin;

  always_comb begin
    paid_sum   = {1'b0, paid} + {2'b00, bus.coin_value};
    coin_legal = 1'b0;
    coin_room  = 1'b0;
    case (bus.coin_value)
      PENT:    begin coin_legal = 1'b1; coin_room = (pent_cnt != 2'd3); end
      TRIC:    begin coin_legal = 1'b1; coin_room = (tri_cnt  != 2'd3); end
      CIRC:    begin coin_legal = 1'b1; coin_room = (cir_cnt  != 2'd3); end
      default: ;
    endcase
    coin_ok   = coin_legal && coin_room && (paid_sum <= 5'd15);
    handshake = disp_valid && bus.disp_ready;

    // Zero codes from the change maker mean "no coin" and are squeezed out.
    chg_head = (bus.FirstCoin != 3'd0) ? bus.FirstCoin : bus.SecondCoin;
    chg_two  = (bus.FirstCoin != 3'd0) && (bus.SecondCoin != 3'd0);

    left_pent = ins_pent;
    left_tri  = ins_tri;
    left_cir  = ins_cir;
    if (handshake && state == REFUND) begin
      case (disp_coin)
        PENT:    left_pent = ins_pent - 2'd1;
        TRIC:    left_tri  = ins_tri  - 2'd1;
        CIRC:    left_cir  = ins_cir  - 2'd1;
        default: ;
      endcase
    end
    if (left_pent != 2'd0)     refund_coin = PENT;
    else if (left_tri != 2'd0) refund_coin = TRIC;
    else if (left_cir != 2'd0) refund_coin = CIRC;
    else                       refund_coin = 3'd0;
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state       <= IDLE;
      cost        <= 4'd0;
      paid        <= 4'd0;
      pent_cnt    <= INIT_PENT;
      tri_cnt     <= INIT_TRI;
      cir_cnt     <= INIT_CIR;
      ins_pent    <= 2'd0;
      ins_tri     <= 2'd0;
      ins_cir     <= 2'd0;
      queue_tail  <= 3'd0;
      queue_two   <= 1'b0;
      coin_reject <= 1'b0;
      disp_valid  <= 1'b0;
      disp_coin   <= 3'd0;
      sale_ok     <= 1'b0;
      sale_fail   <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sale_ok     <= 1'b0;
      sale_fail   <= 1'b0;

      // Any accepted coin leaves the machine, change or refund alike.
      if (handshake) begin
        case (disp_coin)
          PENT:    pent_cnt <= pent_cnt - 2'd1;
          TRIC:    tri_cnt  <= tri_cnt  - 2'd1;
          CIRC:    cir_cnt  <= cir_cnt  - 2'd1;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (bus.item_valid) begin
            cost     <= bus.item_cost;
            paid     <= 4'd0;
            ins_pent <= 2'd0;
            ins_tri  <= 2'd0;
            ins_cir  <= 2'd0;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (bus.cancel) begin
            coin_reject <= bus.coin_valid;
            state       <= REFUND;
          end else if (bus.coin_valid && coin_ok) begin
            paid <= paid_sum[3:0];
            case (bus.coin_value)
              PENT:    begin pent_cnt <= pent_cnt + 2'd1; ins_pent <= ins_pent + 2'd1; end
              TRIC:    begin tri_cnt  <= tri_cnt  + 2'd1; ins_tri  <= ins_tri  + 2'd1; end
              CIRC:    begin cir_cnt  <= cir_cnt  + 2'd1; ins_cir  <= ins_cir  + 2'd1; end
              default: ;
            endcase
          end else begin
            coin_reject <= bus.coin_valid;
            if (!bus.CoughUpMore) state <= DECIDE;
          end
        end

        DECIDE: begin
          if (bus.ExactAmount) begin
            sale_ok <= 1'b1;
            state   <= IDLE;
          end else if (bus.NotEnoughChange || chg_head == 3'd0) begin
            state <= REFUND;
          end else begin
            disp_valid <= 1'b1;
            disp_coin  <= chg_head;
            queue_tail <= bus.SecondCoin;
            queue_two  <= chg_two;
            state      <= DISPENSE;
          end
        end

        DISPENSE: begin
          if (handshake) begin
            if (queue_two) begin
              disp_coin <= queue_tail;
              queue_two <= 1'b0;
            end else begin
              disp_valid <= 1'b0;
              disp_coin  <= 3'd0;
              sale_ok    <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        REFUND: begin
          // Next refund coin is chosen from the counts left after this cycle's handshake.
          if (!disp_valid || handshake) begin
            ins_pent <= left_pent;
            ins_tri  <= left_tri;
            ins_cir  <= left_cir;
            if (refund_coin != 3'd0) begin
              disp_valid <= 1'b1;
              disp_coin  <= refund_coin;
            end else begin
              disp_valid <= 1'b0;
              disp_coin  <= 3'd0;
              sale_fail  <= 1'b1;
              paid       <= 4'd0;
              state      <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Cost        = cost;
  assign bus.Paid        = paid;
  assign bus.Pentagons   = pent_cnt;
  assign bus.Triangles   = tri_cnt;
  assign bus.Circles     = cir_cnt;
  assign bus.coin_reject = coin_reject;
  assign bus.disp_valid  = disp_valid;
  assign bus.disp_coin   = disp_coin;
  assign bus.sale_ok     = sale_ok;
  assign bus.sale_fail   = sale_fail;
  assign bus.busy        = (state != IDLE);
endmodule
